// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory arbiter: state encoding and default sizing.
package mem_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    localparam int DEF_NUM_REQ = 3;
    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_DATA_W  = 32;
    localparam int MAX_REQ     = 4;

endpackage

// File: rtl/mem_arbiter_pick_rr.sv
// Combinational round-robin picker: lowest eligible index at or above the
// pointer wins; if none, the lowest eligible index overall wins (wrap).
module pick_rr #(
    parameter int N  = 3,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_eligible,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic          o_valid
);

    logic          w_hiFound;
    logic [PW-1:0] w_hiIdx;
    logic [PW-1:0] w_loIdx;
    logic [PW-1:0] w_winIdx;

    // Scan downwards so the lowest qualifying index is the last one written.
    always_comb begin
        w_hiFound = 1'b0;
        w_hiIdx   = '0;
        w_loIdx   = '0;
        o_valid   = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_eligible[i]) begin
                o_valid = 1'b1;
                w_loIdx = PW'(i);
                if (PW'(i) >= i_ptr) begin
                    w_hiFound = 1'b1;
                    w_hiIdx   = PW'(i);
                end
            end
        end
        w_winIdx = w_hiFound ? w_hiIdx : w_loIdx;
        o_grant  = o_valid ? (N'(1) << w_winIdx) : '0;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing the memory controller's CPU-side port among
// several masters. One transaction at a time, one dead IDLE cycle between.
// Optional locked follow-on transactions are enabled by MEM_ARB_LOCK_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ-1:0]        req_lock,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_done,
    output logic [DATA_W-1:0]         req_rdata,
    output logic [NUM_REQ-1:0]        arb_grant,
    output logic [ADDR_W-1:0]         ctl_addr,
    output logic [DATA_W-1:0]         ctl_wdata,
    output logic                      ctl_read,
    output logic                      ctl_write,
    input  logic                      ctl_ready,
    input  logic [DATA_W-1:0]         ctl_rdata
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_e         r_state;
    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   r_gidx;
    logic [NUM_REQ-1:0] r_grant;
    logic [NUM_REQ-1:0] r_done;
    logic [DATA_W-1:0]  r_rdata;
    logic [ADDR_W-1:0]  r_ctlAddr;
    logic [DATA_W-1:0]  r_ctlWdata;
    logic               r_ctlRead;
    logic               r_ctlWrite;

    logic [NUM_REQ-1:0] w_elig;
    logic [NUM_REQ-1:0] w_win;
    logic               w_winValid;
    logic [IDX_W-1:0]   w_winIdx;
    logic [ADDR_W-1:0]  w_addr;
    logic [DATA_W-1:0]  w_wdata;
    logic               w_write;
    logic [IDX_W-1:0]   w_nextPtr;

`ifdef MEM_ARB_LOCK_EN
    logic               r_lock;
    logic [NUM_REQ-1:0] w_ptrHot;
    assign w_ptrHot = NUM_REQ'(1) << r_ptr;
`else
    logic               w_unusedLock;
    assign w_unusedLock = ^req_lock;
`endif

    // Eligible set: requesters just completed sit out one cycle, unless a lock holds.
    always_comb begin
        w_elig = req_valid & ~r_done;
`ifdef MEM_ARB_LOCK_EN
        if (r_lock && (|(req_valid & w_ptrHot))) begin
            w_elig = w_ptrHot;
        end
`endif
    end

    pick_rr #(
        .N  (NUM_REQ),
        .PW (IDX_W)
    ) u_pick (
        .i_eligible (w_elig),
        .i_ptr      (r_ptr),
        .o_grant    (w_win),
        .o_valid    (w_winValid)
    );

    // Select the winner's index, address, write data and direction.
    always_comb begin
        w_winIdx = '0;
        w_addr   = '0;
        w_wdata  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win[i]) begin
                w_winIdx = IDX_W'(i);
                w_addr   = req_addr[i*ADDR_W +: ADDR_W];
                w_wdata  = req_wdata[i*DATA_W +: DATA_W];
            end
        end
        w_write   = |(req_write & w_win);
        w_nextPtr = (r_gidx == IDX_W'(NUM_REQ - 1)) ? '0 : r_gidx + 1'b1;
    end

    // Arbitration FSM with registered command and completion outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_gidx     <= '0;
            r_grant    <= '0;
            r_done     <= '0;
            r_rdata    <= '0;
            r_ctlAddr  <= '0;
            r_ctlWdata <= '0;
            r_ctlRead  <= 1'b0;
            r_ctlWrite <= 1'b0;
`ifdef MEM_ARB_LOCK_EN
            r_lock     <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= '0;
`ifdef MEM_ARB_LOCK_EN
                    r_lock <= 1'b0;
`endif
                    if (w_winValid) begin
                        r_grant    <= w_win;
                        r_gidx     <= w_winIdx;
                        r_ctlAddr  <= w_addr;
                        r_ctlWdata <= w_wdata;
                        r_ctlRead  <= ~w_write;
                        r_ctlWrite <= w_write;
                        r_state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (ctl_ready) begin
                        r_rdata    <= ctl_rdata;
                        r_done     <= r_grant;
                        r_grant    <= '0;
                        r_ctlRead  <= 1'b0;
                        r_ctlWrite <= 1'b0;
                        r_state    <= IDLE;
`ifdef MEM_ARB_LOCK_EN
                        r_lock     <= |(req_lock & r_grant);
                        r_ptr      <= (|(req_lock & r_grant)) ? r_gidx : w_nextPtr;
`else
                        r_ptr      <= w_nextPtr;
`endif
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_done  = r_done;
    assign req_rdata = r_rdata;
    assign arb_grant = r_grant;
    assign ctl_addr  = r_ctlAddr;
    assign ctl_wdata = r_ctlWdata;
    assign ctl_read  = r_ctlRead;
    assign ctl_write = r_ctlWrite;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed table-driven bench for mem_arbiter (3 requesters, 32-bit paths).
// Covers the locked follow-on behaviour when MEM_ARB_LOCK_EN is defined.
module tb_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic [2:0]  reqValid;
    logic [2:0]  reqWrite;
    logic [2:0]  reqLock;
    logic [95:0] reqAddr;
    logic [95:0] reqWdata;
    logic [2:0]  reqDone;
    logic [31:0] reqRdata;
    logic [2:0]  arbGrant;
    logic [31:0] ctlAddr;
    logic [31:0] ctlWdata;
    logic        ctlRead;
    logic        ctlWrite;
    logic        ctlReady;
    logic [31:0] ctlRdata;

    int nVec  = 0;
    int nFail = 0;

    typedef struct {
        logic [2:0]  valid;
        logic [2:0]  write;
        logic [2:0]  lock;
        logic        ready;
        logic [31:0] rdata;
        logic [2:0]  expGrant;
        logic [2:0]  expDone;
        logic        expRead;
        logic        expWrite;
        logic        chkRdata;
        logic [31:0] expRdata;
    } vec_t;

    vec_t vecs[$];

    logic [31:0] addrTab  [3];
    logic [31:0] wdataTab [3];

    mem_arbiter #(
        .NUM_REQ (3),
        .ADDR_W  (32),
        .DATA_W  (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (reqValid),
        .req_write (reqWrite),
        .req_lock  (reqLock),
        .req_addr  (reqAddr),
        .req_wdata (reqWdata),
        .req_done  (reqDone),
        .req_rdata (reqRdata),
        .arb_grant (arbGrant),
        .ctl_addr  (ctlAddr),
        .ctl_wdata (ctlWdata),
        .ctl_read  (ctlRead),
        .ctl_write (ctlWrite),
        .ctl_ready (ctlReady),
        .ctl_rdata (ctlRdata)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Guard against a hung run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int hotIdx(input logic [2:0] h);
        case (h)
            3'b001:  return 0;
            3'b010:  return 1;
            3'b100:  return 2;
            default: return 0;
        endcase
    endfunction

    task automatic checkOutput(input string name, input int idx,
                               input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s (step %0d): got %h want %h", name, idx, act, exp);
        end
    endtask

    task automatic addVec(input logic [2:0] valid, input logic [2:0] write,
                          input logic [2:0] lock, input logic ready,
                          input logic [31:0] rdata, input logic [2:0] eGrant,
                          input logic [2:0] eDone, input logic eRead,
                          input logic eWrite, input logic chkR,
                          input logic [31:0] eRdata);
        vec_t v;
        v.valid = valid;  v.write = write;  v.lock = lock;
        v.ready = ready;  v.rdata = rdata;
        v.expGrant = eGrant;  v.expDone = eDone;
        v.expRead = eRead;    v.expWrite = eWrite;
        v.chkRdata = chkR;    v.expRdata = eRdata;
        vecs.push_back(v);
    endtask

    // Applies each queued vector for one clock and checks outputs 1 ns after the edge.
    task automatic applyStimulus(input string tag);
        foreach (vecs[i]) begin
            reqValid = vecs[i].valid;
            reqWrite = vecs[i].write;
            reqLock  = vecs[i].lock;
            ctlReady = vecs[i].ready;
            ctlRdata = vecs[i].rdata;
            @(posedge clk);
            #1;
            checkOutput({tag, " grant"}, i, 32'(arbGrant), 32'(vecs[i].expGrant));
            checkOutput({tag, " done"},  i, 32'(reqDone),  32'(vecs[i].expDone));
            checkOutput({tag, " read"},  i, 32'(ctlRead),  32'(vecs[i].expRead));
            checkOutput({tag, " write"}, i, 32'(ctlWrite), 32'(vecs[i].expWrite));
            if (vecs[i].chkRdata)
                checkOutput({tag, " rdata"}, i, reqRdata, vecs[i].expRdata);
            if (vecs[i].expGrant != 3'b000) begin
                checkOutput({tag, " addr"},  i, ctlAddr,  addrTab[hotIdx(vecs[i].expGrant)]);
                checkOutput({tag, " wdata"}, i, ctlWdata, wdataTab[hotIdx(vecs[i].expGrant)]);
            end
        end
        vecs.delete();
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " grant"}, 0, 32'(arbGrant), 32'h0);
        checkOutput({tag, " done"},  0, 32'(reqDone),  32'h0);
        checkOutput({tag, " read"},  0, 32'(ctlRead),  32'h0);
        checkOutput({tag, " write"}, 0, 32'(ctlWrite), 32'h0);
        checkOutput({tag, " addr"},  0, ctlAddr,       32'h0);
        checkOutput({tag, " wdata"}, 0, ctlWdata,      32'h0);
        checkOutput({tag, " rdata"}, 0, reqRdata,      32'h0);
    endtask

    task automatic applyReset(input string tag);
        reqValid = '0;  reqWrite = '0;  reqLock = '0;
        ctlReady = 1'b0; ctlRdata = '0;
        rst_n = 1'b0;
        #2;
        checkAllZero(tag);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        addrTab[0]  = 32'h0000_1000;  wdataTab[0] = 32'hA0A0_A0A0;
        addrTab[1]  = 32'h8000_0010;  wdataTab[1] = 32'h1234_5678;
        addrTab[2]  = 32'h0000_2000;  wdataTab[2] = 32'hC0C0_C0C0;
        reqAddr  = {addrTab[2], addrTab[1], addrTab[0]};
        reqWdata = {wdataTab[2], wdataTab[1], wdataTab[0]};
        rst_n = 1'b1;
        reqValid = '0;  reqWrite = '0;  reqLock = '0;
        ctlReady = 1'b0; ctlRdata = '0;
        #3;

        applyReset("reset");

        // Single read, ready two cycles after the command appears.
        //     valid   write   lock    rdy   rdata         grant   done    rd    wr    chk   rdata
        addVec(3'b001, 3'b000, 3'b000, 1'b0, 32'h0,        3'b001, 3'b000, 1'b1, 1'b0, 1'b1, 32'h0);
        addVec(3'b001, 3'b000, 3'b000, 1'b0, 32'h0,        3'b001, 3'b000, 1'b1, 1'b0, 1'b0, 32'h0);
        addVec(3'b001, 3'b000, 3'b000, 1'b0, 32'h0,        3'b001, 3'b000, 1'b1, 1'b0, 1'b0, 32'h0);
        addVec(3'b001, 3'b000, 3'b000, 1'b1, 32'hDEADBEEF, 3'b000, 3'b001, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF);
        addVec(3'b000, 3'b000, 3'b000, 1'b0, 32'h0,        3'b000, 3'b000, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF);
        applyStimulus("single_read");

        applyReset("reset2");

        // All three request continuously: order 0,1,2,0 with one idle cycle between.
        addVec(3'b111, 3'b000, 3'b000, 1'b0, 32'h0,        3'b001, 3'b000, 1'b1, 1'b0, 1'b0, 32'h0);
        addVec(3'b111, 3'b000, 3'b000, 1'b0, 32'h0,        3'b001, 3'b000, 1'b1, 1'b0, 1'b0, 32'h0);
        addVec(3'b111, 3'b000, 3'b000, 1'b1, 32'h11111111, 3'b000, 3'b001, 1'b0, 1'b0, 1'b1, 32'h11111111);
        addVec(3'b111, 3'b000, 3'b000, 1'b0, 32'h0,        3'b010, 3'b000, 1'b1, 1'b0, 1'b0, 32'h0);
        addVec(3'b111, 3'b000, 3'b000, 1'b0, 32'h0,        3'b010, 3'b000, 1'b1, 1'b0, 1'b0, 32'h0);
        addVec(3'b111, 3'b000, 3'b000, 1'b1, 32'h22222222, 3'b000, 3'b010, 1'b0, 1'b0, 1'b1, 32'h22222222);
        addVec(3'b111, 3'b000, 3'b000, 1'b0, 32'h0,        3'b100, 3'b000, 1'b1, 1'b0, 1'b0, 32'h0);
        addVec(3'b111, 3'b000, 3'b000, 1'b0, 32'h0,        3'b100, 3'b000, 1'b1, 1'b0, 1'b0, 32'h0);
        addVec(3'b111, 3'b000, 3'b000, 1'b1, 32'h33333333, 3'b000, 3'b100, 1'b0, 1'b0, 1'b1, 32'h33333333);
        addVec(3'b111, 3'b000, 3'b000, 1'b0, 32'h0,        3'b001, 3'b000, 1'b1, 1'b0, 1'b0, 32'h0);
        addVec(3'b111, 3'b000, 3'b000, 1'b0, 32'h0,        3'b001, 3'b000, 1'b1, 1'b0, 1'b0, 32'h0);
        addVec(3'b111, 3'b000, 3'b000, 1'b1, 32'h44444444, 3'b000, 3'b001, 1'b0, 1'b0, 1'b1, 32'h44444444);
        addVec(3'b000, 3'b000, 3'b000, 1'b0, 32'h0,        3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0);
        applyStimulus("rr_order");

        // Requester 1 writes and keeps requesting through its done cycle.
        addVec(3'b010, 3'b010, 3'b000, 1'b0, 32'h0,        3'b010, 3'b000, 1'b0, 1'b1, 1'b0, 32'h0);
        addVec(3'b010, 3'b010, 3'b000, 1'b1, 32'h0,        3'b000, 3'b010, 1'b0, 1'b0, 1'b0, 32'h0);
        addVec(3'b010, 3'b010, 3'b000, 1'b0, 32'h0,        3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0);
        addVec(3'b010, 3'b010, 3'b000, 1'b0, 32'h0,        3'b010, 3'b000, 1'b0, 1'b1, 1'b0, 32'h0);
        addVec(3'b010, 3'b010, 3'b000, 1'b1, 32'h0,        3'b000, 3'b010, 1'b0, 1'b0, 1'b0, 32'h0);
        addVec(3'b000, 3'b000, 3'b000, 1'b0, 32'h0,        3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0);
        applyStimulus("write_rereq");

        // Requester 2 drops valid mid-transaction; then a stray ready in idle.
        addVec(3'b100, 3'b000, 3'b000, 1'b0, 32'h0,        3'b100, 3'b000, 1'b1, 1'b0, 1'b0, 32'h0);
        addVec(3'b000, 3'b000, 3'b000, 1'b0, 32'h0,        3'b100, 3'b000, 1'b1, 1'b0, 1'b0, 32'h0);
        addVec(3'b000, 3'b000, 3'b000, 1'b1, 32'h5A5A5A5A, 3'b000, 3'b100, 1'b0, 1'b0, 1'b1, 32'h5A5A5A5A);
        addVec(3'b000, 3'b000, 3'b000, 1'b0, 32'h0,        3'b000, 3'b000, 1'b0, 1'b0, 1'b1, 32'h5A5A5A5A);
        addVec(3'b000, 3'b000, 3'b000, 1'b1, 32'h99999999, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1, 32'h5A5A5A5A);
        applyStimulus("drop_valid");

        // Move the pointer off zero, then reset while requester 2 is busy.
        addVec(3'b010, 3'b000, 3'b000, 1'b0, 32'h0,        3'b010, 3'b000, 1'b1, 1'b0, 1'b0, 32'h0);
        addVec(3'b010, 3'b000, 3'b000, 1'b1, 32'h00000077, 3'b000, 3'b010, 1'b0, 1'b0, 1'b1, 32'h00000077);
        addVec(3'b100, 3'b000, 3'b000, 1'b0, 32'h0,        3'b100, 3'b000, 1'b1, 1'b0, 1'b0, 32'h0);
        applyStimulus("pre_reset");
        #2;
        rst_n = 1'b0;
        #1;
        checkAllZero("reset_busy");
        reqValid = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        addVec(3'b111, 3'b000, 3'b000, 1'b0, 32'h0,        3'b001, 3'b000, 1'b1, 1'b0, 1'b1, 32'h0);
        addVec(3'b111, 3'b000, 3'b000, 1'b1, 32'h00000088, 3'b000, 3'b001, 1'b0, 1'b0, 1'b1, 32'h00000088);
        addVec(3'b000, 3'b000, 3'b000, 1'b0, 32'h0,        3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0);
        applyStimulus("post_reset");

        applyReset("reset3");

`ifdef MEM_ARB_LOCK_EN
        // Requester 2 holds the lock for three transactions, then releases.
        addVec(3'b100, 3'b000, 3'b100, 1'b0, 32'h0,        3'b100, 3'b000, 1'b1, 1'b0, 1'b0, 32'h0);
        addVec(3'b111, 3'b000, 3'b100, 1'b1, 32'h000000A1, 3'b000, 3'b100, 1'b0, 1'b0, 1'b1, 32'h000000A1);
        addVec(3'b111, 3'b000, 3'b100, 1'b0, 32'h0,        3'b100, 3'b000, 1'b1, 1'b0, 1'b0, 32'h0);
        addVec(3'b111, 3'b000, 3'b100, 1'b1, 32'h000000A2, 3'b000, 3'b100, 1'b0, 1'b0, 1'b1, 32'h000000A2);
        addVec(3'b111, 3'b000, 3'b100, 1'b0, 32'h0,        3'b100, 3'b000, 1'b1, 1'b0, 1'b0, 32'h0);
        addVec(3'b111, 3'b000, 3'b000, 1'b1, 32'h000000A3, 3'b000, 3'b100, 1'b0, 1'b0, 1'b1, 32'h000000A3);
        addVec(3'b011, 3'b000, 3'b000, 1'b0, 32'h0,        3'b001, 3'b000, 1'b1, 1'b0, 1'b0, 32'h0);
        addVec(3'b011, 3'b000, 3'b000, 1'b1, 32'h000000B1, 3'b000, 3'b001, 1'b0, 1'b0, 1'b1, 32'h000000B1);
        addVec(3'b010, 3'b000, 3'b000, 1'b0, 32'h0,        3'b010, 3'b000, 1'b1, 1'b0, 1'b0, 32'h0);
        addVec(3'b010, 3'b000, 3'b000, 1'b1, 32'h000000B2, 3'b000, 3'b010, 1'b0, 1'b0, 1'b1, 32'h000000B2);
        addVec(3'b000, 3'b000, 3'b000, 1'b0, 32'h0,        3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0);
        applyStimulus("lock");
`else
        // Without the lock feature req_lock has no effect on rotation.
        addVec(3'b100, 3'b000, 3'b100, 1'b0, 32'h0,        3'b100, 3'b000, 1'b1, 1'b0, 1'b0, 32'h0);
        addVec(3'b111, 3'b000, 3'b100, 1'b1, 32'h000000A1, 3'b000, 3'b100, 1'b0, 1'b0, 1'b1, 32'h000000A1);
        addVec(3'b111, 3'b000, 3'b100, 1'b0, 32'h0,        3'b001, 3'b000, 1'b1, 1'b0, 1'b0, 32'h0);
        addVec(3'b111, 3'b000, 3'b100, 1'b1, 32'h000000B1, 3'b000, 3'b001, 1'b0, 1'b0, 1'b1, 32'h000000B1);
        addVec(3'b111, 3'b000, 3'b100, 1'b0, 32'h0,        3'b010, 3'b000, 1'b1, 1'b0, 1'b0, 32'h0);
        addVec(3'b111, 3'b000, 3'b100, 1'b1, 32'h000000C1, 3'b000, 3'b010, 1'b0, 1'b0, 1'b1, 32'h000000C1);
        addVec(3'b000, 3'b000, 3'b000, 1'b0, 32'h0,        3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0);
        applyStimulus("nolock");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end

endmodule
